sc_shifter_ctrl: RTL and testbench

SC_SHIFTER_CTRL -- requirements
Module: sc_shifter_ctrl

---
 rtl/sc_shifter_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sc_shifter_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_shifter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sc_shifter_ctrl
// Button controller for a shift register: load, single shift, hold-to-repeat.
// Rev    : 1.0
// ============================================================================

module sc_shifter_ctrl #(
  parameter int                   DATAWIDTH     = 8,
  parameter logic [DATAWIDTH-1:0] INIT_VALUE    = 8'b00000001,
  parameter int                   CNT_WIDTH     = 24,
  parameter int                   REPEAT_DELAY  = 12500000,
  parameter int                   REPEAT_PERIOD = 5000000
) (
  input  logic                 sc_shifter_ctrl_CLOCK_50,
  input  logic                 sc_shifter_ctrl_RESET_InLow,
  input  logic                 sc_shifter_ctrl_left_InLow,
  input  logic                 sc_shifter_ctrl_right_InLow,
  input  logic                 sc_shifter_ctrl_reload_InLow,
  output logic                 sc_shifter_ctrl_load_OutLow,
  output logic [1:0]           sc_shifter_ctrl_shiftselection_Out,
  output logic [DATAWIDTH-1:0] sc_shifter_ctrl_data_OutBUS,
  output logic                 sc_shifter_ctrl_busy_Out
);

  typedef enum logic [2:0] {
    S_INIT         = 3'd0,
    S_IDLE         = 3'd1,
    S_SHIFT        = 3'd2,
    S_WAIT_DELAY   = 3'd3,
    S_WAIT_PERIOD  = 3'd4,
    S_WAIT_RELEASE = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] c_PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

  // Button bits: [0] left, [1] right, [2] reload; 1 = released.
  logic [2:0] r_btnMeta;
  logic [2:0] r_btnSync;

  state_t               r_state;
  logic                 r_dir;
  logic                 r_isRepeat;
  logic [CNT_WIDTH-1:0] r_count;

  state_t               w_nextState;
  logic                 w_nextDir;
  logic                 w_nextRepeat;
  logic [CNT_WIDTH-1:0] w_nextCount;
  logic                 w_left;
  logic                 w_right;
  logic                 w_reload;
  logic                 w_dirHeld;
  logic                 w_oppHeld;
  logic [CNT_WIDTH-1:0] w_waitLast;

  assign sc_shifter_ctrl_data_OutBUS = INIT_VALUE;

  always_ff @(posedge sc_shifter_ctrl_CLOCK_50 or negedge sc_shifter_ctrl_RESET_InLow) begin
    if (!sc_shifter_ctrl_RESET_InLow) begin
      r_btnMeta <= 3'b111;
      r_btnSync <= 3'b111;
    end else begin
      r_btnMeta <= {sc_shifter_ctrl_reload_InLow, sc_shifter_ctrl_right_InLow,
                    sc_shifter_ctrl_left_InLow};
      r_btnSync <= r_btnMeta;
    end
  end

  assign w_left     = ~r_btnSync[0];
  assign w_right    = ~r_btnSync[1];
  assign w_reload   = ~r_btnSync[2];
  assign w_dirHeld  = r_dir ? w_right : w_left;
  assign w_oppHeld  = r_dir ? w_left  : w_right;
  assign w_waitLast = (r_state == S_WAIT_DELAY) ? c_DELAY_LAST : c_PERIOD_LAST;

  always_comb begin
    w_nextState  = r_state;
    w_nextDir    = r_dir;
    w_nextRepeat = r_isRepeat;
    w_nextCount  = r_count;
    case (r_state)
      S_INIT: begin
        w_nextState = (w_left || w_right || w_reload) ? S_WAIT_RELEASE : S_IDLE;
      end
      S_IDLE: begin
        if (w_reload) begin
          w_nextState = S_INIT;
        end else if (w_left && w_right) begin
          w_nextState = S_WAIT_RELEASE;
        end else if (w_left || w_right) begin
          w_nextState  = S_SHIFT;
          w_nextDir    = w_right;
          w_nextRepeat = 1'b0;
        end
      end
      S_SHIFT: begin
        if (w_reload) begin
          w_nextState = S_INIT;
        end else begin
          w_nextCount = '0;
          w_nextState = r_isRepeat ? S_WAIT_PERIOD : S_WAIT_DELAY;
        end
      end
      S_WAIT_DELAY, S_WAIT_PERIOD: begin
        // Release and opposite-press both outrank the repeat count.
        if (w_reload) begin
          w_nextState = S_INIT;
        end else if (!w_dirHeld) begin
          w_nextState = S_IDLE;
        end else if (w_oppHeld) begin
          w_nextState = S_WAIT_RELEASE;
        end else if (r_count == w_waitLast) begin
          w_nextState  = S_SHIFT;
          w_nextRepeat = 1'b1;
        end else begin
          w_nextCount = r_count + 1'b1;
        end
      end
      S_WAIT_RELEASE: begin
        if (w_reload) begin
          w_nextState = S_INIT;
        end else if (!w_left && !w_right) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_INIT;
      end
    endcase
  end

  // Outputs are registered from the next state so they stay glitch-free Moore outputs.
  always_ff @(posedge sc_shifter_ctrl_CLOCK_50 or negedge sc_shifter_ctrl_RESET_InLow) begin
    if (!sc_shifter_ctrl_RESET_InLow) begin
      r_state                            <= S_INIT;
      r_dir                              <= 1'b0;
      r_isRepeat                         <= 1'b0;
      r_count                            <= '0;
      sc_shifter_ctrl_load_OutLow        <= 1'b0;
      sc_shifter_ctrl_shiftselection_Out <= 2'b00;
      sc_shifter_ctrl_busy_Out           <= 1'b1;
    end else begin
      r_state                     <= w_nextState;
      r_dir                       <= w_nextDir;
      r_isRepeat                  <= w_nextRepeat;
      r_count                     <= w_nextCount;
      sc_shifter_ctrl_load_OutLow <= (w_nextState != S_INIT);
      sc_shifter_ctrl_busy_Out    <= (w_nextState != S_IDLE);
      if (w_nextState == S_SHIFT) begin
        sc_shifter_ctrl_shiftselection_Out <= w_nextDir ? 2'b10 : 2'b01;
      end else begin
        sc_shifter_ctrl_shiftselection_Out <= 2'b00;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sc_shifter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_sc_shifter_ctrl
// Self-checking bench for sc_shifter_ctrl with a press-age behavioural model.
// Rev    : 1.0
// ============================================================================

module tb_sc_shifter_ctrl;

  localparam int c_D = 4;
  localparam int c_P = 2;

  localparam logic [2:0] M_INIT    = 3'd0;
  localparam logic [2:0] M_IDLE    = 3'd1;
  localparam logic [2:0] M_ACTIVE  = 3'd2;
  localparam logic [2:0] M_BLOCKED = 3'd3;

  typedef struct packed {
    logic [2:0]  mode;
    logic [15:0] age;
    logic        dir;
  } mstate_t;

  logic       clk;
  logic       rst_n;
  logic       left_n;
  logic       right_n;
  logic       reload_n;
  logic       load_n;
  logic [1:0] shiftSel;
  logic [7:0] dataBus;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int k;
  int k2;
  int pulseCyc[$];
  logic [1:0] pulseVal[$];
  int loadCyc[$];

  mstate_t    m;
  logic [2:0] mS1;
  logic [2:0] mS2;

  sc_shifter_ctrl #(
    .DATAWIDTH    (8),
    .INIT_VALUE   (8'b00000001),
    .CNT_WIDTH    (24),
    .REPEAT_DELAY (c_D),
    .REPEAT_PERIOD(c_P)
  ) dut (
    .sc_shifter_ctrl_CLOCK_50          (clk),
    .sc_shifter_ctrl_RESET_InLow       (rst_n),
    .sc_shifter_ctrl_left_InLow        (left_n),
    .sc_shifter_ctrl_right_InLow       (right_n),
    .sc_shifter_ctrl_reload_InLow      (reload_n),
    .sc_shifter_ctrl_load_OutLow       (load_n),
    .sc_shifter_ctrl_shiftselection_Out(shiftSel),
    .sc_shifter_ctrl_data_OutBUS       (dataBus),
    .sc_shifter_ctrl_busy_Out          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A press of age a shifts at 0, D+1, then every P+1 cycles.
  function automatic bit isPulseAge(input logic [15:0] a);
    int ai;
    ai = int'(a);
    return (ai == 0) || (ai == c_D + 1) ||
           ((ai > c_D + 1) && (((ai - c_D - 1) % (c_P + 1)) == 0));
  endfunction

  function automatic mstate_t step(input mstate_t cur, input logic [2:0] s);
    mstate_t nx;
    bit l, r, ld;
    nx = cur;
    l  = !s[0];
    r  = !s[1];
    ld = !s[2];
    if (cur.mode == M_INIT) begin
      nx.mode = (l || r || ld) ? M_BLOCKED : M_IDLE;
    end else if (ld) begin
      nx.mode = M_INIT;
    end else if (cur.mode == M_IDLE) begin
      if (l && r) nx.mode = M_BLOCKED;
      else if (l || r) begin
        nx.mode = M_ACTIVE;
        nx.dir  = r;
        nx.age  = 16'd0;
      end
    end else if (cur.mode == M_ACTIVE) begin
      if (isPulseAge(cur.age)) nx.age = cur.age + 16'd1;
      else if (cur.dir ? !r : !l) nx.mode = M_IDLE;
      else if (cur.dir ? l : r) nx.mode = M_BLOCKED;
      else nx.age = cur.age + 16'd1;
    end else if (cur.mode == M_BLOCKED) begin
      if (!l && !r) nx.mode = M_IDLE;
    end
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= '{mode: M_INIT, age: 16'd0, dir: 1'b0};
      mS1 <= 3'b111;
      mS2 <= 3'b111;
    end else begin
      m   <= step(m, mS2);
      mS2 <= mS1;
      mS1 <= {reload_n, right_n, left_n};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [1:0] expShift;
    expShift = (m.mode == M_ACTIVE && isPulseAge(m.age)) ? (m.dir ? 2'b10 : 2'b01) : 2'b00;
    check("model_load",  32'(load_n),   32'(m.mode != M_INIT));
    check("model_shift", 32'(shiftSel), 32'(expShift));
    check("model_busy",  32'(busy),     32'(m.mode != M_IDLE));
    check("data_bus",    32'(dataBus),  32'h01);
    if (shiftSel != 2'b00) begin
      pulseCyc.push_back(cyc);
      pulseVal.push_back(shiftSel);
    end
    if (!load_n) loadCyc.push_back(cyc);
  end

  initial begin
    int offs[6];
    offs = '{0, 5, 8, 11, 14, 17};
    rst_n    = 1'b0;
    left_n   = 1'b1;
    right_n  = 1'b1;
    reload_n = 1'b1;

    // Reset hold values and one-cycle INIT after release.
    nclk(3);
    #1;
    check("rst_load",  32'(load_n),   32'd0);
    check("rst_busy",  32'(busy),     32'd1);
    check("rst_shift", 32'(shiftSel), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("init_load", 32'(load_n),  32'd0);
    check("init_data", 32'(dataBus), 32'h01);
    @(negedge clk);
    check("idle_load",  32'(load_n),   32'd1);
    check("idle_busy",  32'(busy),     32'd0);
    check("idle_shift", 32'(shiftSel), 32'd0);

    // Short left press: single 01 pulse after edge k+2.
    nclk(2);
    pulseCyc.delete(); pulseVal.delete();
    k = cyc + 1;
    left_n = 1'b0;
    nclk(2);
    left_n = 1'b1;
    nclk(8);
    check("short_left_count", 32'(pulseCyc.size()), 32'd1);
    if (pulseCyc.size() > 0) begin
      check("short_left_cyc", 32'(pulseCyc[0]), 32'(k + 2));
      check("short_left_val", 32'(pulseVal[0]), 32'd1);
    end

    // Right held 20 cycles: pulses at t, t+5, t+8, t+11, t+14, t+17.
    pulseCyc.delete(); pulseVal.delete();
    k = cyc + 1;
    right_n = 1'b0;
    nclk(20);
    right_n = 1'b1;
    nclk(3);
    check("hold_right_idle", 32'(busy), 32'd0);
    nclk(3);
    check("hold_right_count", 32'(pulseCyc.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < pulseCyc.size()) begin
        check("hold_right_cyc", 32'(pulseCyc[i]), 32'(k + 2 + offs[i]));
        check("hold_right_val", 32'(pulseVal[i]), 32'd2);
      end
    end

    // Both buttons: never shifts, idle only once both are released.
    pulseCyc.delete(); pulseVal.delete();
    left_n  = 1'b0;
    right_n = 1'b0;
    nclk(5);
    left_n = 1'b1;
    nclk(4);
    check("both_still_busy", 32'(busy), 32'd1);
    right_n = 1'b1;
    nclk(4);
    check("both_idle", 32'(busy), 32'd0);
    check("both_no_pulse", 32'(pulseCyc.size()), 32'd0);

    // Reload during WAIT_PERIOD with left held.
    pulseCyc.delete(); pulseVal.delete(); loadCyc.delete();
    k = cyc + 1;
    left_n = 1'b0;
    nclk(7);
    reload_n = 1'b0;
    nclk(1);
    reload_n = 1'b1;
    nclk(12);
    check("reload_load_count", 32'(loadCyc.size()), 32'd1);
    if (loadCyc.size() > 0) check("reload_load_cyc", 32'(loadCyc[0]), 32'(k + 9));
    check("reload_pulse_count", 32'(pulseCyc.size()), 32'd2);
    if (pulseCyc.size() > 1) begin
      check("reload_pulse0", 32'(pulseCyc[0]), 32'(k + 2));
      check("reload_pulse1", 32'(pulseCyc[1]), 32'(k + 7));
    end
    check("reload_wait_release", 32'(busy), 32'd1);
    left_n = 1'b1;
    nclk(4);
    check("reload_idle", 32'(busy), 32'd0);
    k2 = cyc + 1;
    left_n = 1'b0;
    nclk(2);
    left_n = 1'b1;
    nclk(6);
    check("repress_count", 32'(pulseCyc.size()), 32'd3);
    if (pulseCyc.size() > 2) check("repress_cyc", 32'(pulseCyc[2]), 32'(k2 + 2));

    // Asynchronous reset in the SHIFT cycle.
    k = cyc + 1;
    right_n = 1'b0;
    nclk(3);
    check("pre_reset_shift", 32'(shiftSel), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_shift", 32'(shiftSel),    32'd0);
    check("async_rst_load",  32'(load_n),      32'd0);
    check("async_rst_busy",  32'(busy),        32'd1);
    check("async_rst_count", 32'(dut.r_count), 32'd0);
    right_n = 1'b1;
    nclk(2);
    @(posedge clk);
    #1 rst_n = 1'b1;
    nclk(3);
    check("post_rst_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
